// File: rtl/dmem_pkg.sv
// Shared constants and address-decode helpers for the data-memory responder.
// Timer registers decode here in every build; dmem_responder gates them with DMEM_TIMER_EN.
package dmem_pkg;

    localparam logic [31:0] DMEM_MMIO_BASE = 32'h0000_8000;

    localparam logic [3:0] GPIO_OFS     = 4'h0;
    localparam logic [3:0] MTIME_OFS    = 4'h4;
    localparam logic [3:0] MTIMECMP_OFS = 4'h8;
    localparam logic [3:0] STATUS_OFS   = 4'hC;

    localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_GPIO,
        SEL_MTIME,
        SEL_MTIMECMP,
        SEL_STATUS
    } dmem_sel_e;

    // Word-aligned offset within the 16-byte peripheral window.
    function automatic dmem_sel_e decodeMmio(input logic [3:0] ofs);
        dmem_sel_e sel;
        case (ofs)
            GPIO_OFS:     sel = SEL_GPIO;
            MTIME_OFS:    sel = SEL_MTIME;
            MTIMECMP_OFS: sel = SEL_MTIMECMP;
            STATUS_OFS:   sel = SEL_STATUS;
            default:      sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Machine timer: free-running MTIME, MTIMECMP and a sticky compare-pending flag.
// Instantiated by dmem_responder only when DMEM_TIMER_EN is defined.
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mtime_we_i,
    input  logic        mtimecmp_we_i,
    input  logic        status_clr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] mtime_o,
    output logic [31:0] mtimecmp_o,
    output logic        pending_o
);

    logic [31:0] mtime_q, mtime_d;
    logic [31:0] mtimecmp_q, mtimecmp_d;
    logic        pending_q, pending_d;
    logic        match;

    assign match = (mtime_q == mtimecmp_q);

    // A software load replaces the increment; a fresh match beats a clear.
    always_comb begin
        mtime_d    = mtime_we_i ? wdata_i : mtime_q + 32'd1;
        mtimecmp_d = mtimecmp_we_i ? wdata_i : mtimecmp_q;
        pending_d  = pending_q;
        if (match) begin
            pending_d = 1'b1;
        end else if (status_clr_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            pending_q  <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            pending_q  <= pending_d;
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = mtimecmp_q;
    assign pending_o  = pending_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus GPIO and an optional machine timer in MMIO.
// Define DMEM_TIMER_EN to build the timer (MTIME/MTIMECMP/STATUS, timer_irq).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = DMEM_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] ramIndex;
    logic                  inRam;
    logic                  inMmio;
    dmem_sel_e             sel;
    logic [7:0]            gpio_q, gpio_d;
    logic                  unusedAddrBits;

    assign ramIndex       = addr[ADDR_WIDTH+1:2];
    assign inRam          = (addr[31:ADDR_WIDTH+2] == '0);
    assign inMmio         = (addr[31:4] == MMIO_BASE[31:4]);
    assign unusedAddrBits = ^addr[1:0];

    // RAM takes priority should a custom MMIO_BASE ever overlap it.
    always_comb begin
        sel = SEL_NONE;
        if (inRam) begin
            sel = SEL_RAM;
        end else if (inMmio) begin
            sel = decodeMmio({addr[3:2], 2'b00});
        end
    end

    always_ff @(posedge clk) begin
        if (memwrite && sel == SEL_RAM) begin
            mem_q[ramIndex] <= write_data;
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (memwrite && sel == SEL_GPIO) begin
            gpio_d = write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q <= '0;
        end else begin
            gpio_q <= gpio_d;
        end
    end

    assign gpio_out = gpio_q;

`ifdef DMEM_TIMER_EN
    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic        pending;

    dmem_timer u_timer (
        .clk_i        (clk),
        .reset_i      (reset),
        .mtime_we_i   (memwrite && sel == SEL_MTIME),
        .mtimecmp_we_i(memwrite && sel == SEL_MTIMECMP),
        .status_clr_i (memwrite && sel == SEL_STATUS && write_data[0]),
        .wdata_i      (write_data),
        .mtime_o      (mtime),
        .mtimecmp_o   (mtimecmp),
        .pending_o    (pending)
    );

    assign timer_irq = pending;
`else
    assign timer_irq = 1'b0;
`endif

    // Combinational read path; the single-cycle core needs data in the same cycle.
    always_comb begin
        read_data = '0;
        case (sel)
            SEL_RAM:      read_data = mem_q[ramIndex];
            SEL_GPIO:     read_data = {24'h0, gpio_q};
`ifdef DMEM_TIMER_EN
            SEL_MTIME:    read_data = mtime;
            SEL_MTIMECMP: read_data = mtimecmp;
            SEL_STATUS:   read_data = {31'h0, pending};
`endif
            default:      read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, GPIO, unmapped space and, with DMEM_TIMER_EN, the timer.
module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .write_data(write_data),
        .read_data (read_data),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic writeWord(input logic [31:0] a, input logic [31:0] d);
        addr       = a;
        write_data = d;
        memwrite   = 1'b1;
        @(negedge clk);
        memwrite   = 1'b0;
    endtask

    task automatic readWord(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = read_data;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_gpio: got %h want 00", gpio_out); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq: got %b want 0", timer_irq); end
        readWord(MMIO, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rst_gpio_rd: got %h want 0", v); end
`ifdef DMEM_TIMER_EN
        readWord(MMIO + 32'h4, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rst_mtime: got %h want 0", v); end
        readWord(MMIO + 32'h8, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rst_mtimecmp: got %h want ffffffff", v); end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ram();
        logic [31:0] v;
        writeWord(32'h10, 32'hDEAD_BEEF);
        readWord(32'h10, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_10: got %h want deadbeef", v); end
        readWord(32'h13, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_13: got %h want deadbeef", v); end
        writeWord(32'h20, 32'h1111_1111);
        addr = 32'h20; write_data = 32'h2222_2222; memwrite = 1'b1;
        #1;
        checks++; if (read_data !== 32'h1111_1111) begin errors++; $display("[TB] FAIL ram_same_cycle: got %h want 11111111", read_data); end
        @(negedge clk);
        memwrite = 1'b0;
        readWord(32'h20, v);
        checks++; if (v !== 32'h2222_2222) begin errors++; $display("[TB] FAIL ram_next_cycle: got %h want 22222222", v); end
        writeWord(32'hFFC, 32'hCAFE_F00D);
        writeWord(32'h0, 32'hAAAA_0001);
        writeWord(32'h1000, 32'hBBBB_0002);
        readWord(32'hFFC, v);
        checks++; if (v !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL ram_top: got %h want cafef00d", v); end
        readWord(32'h0, v);
        checks++; if (v !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL ram_no_alias: got %h want aaaa0001", v); end
        readWord(32'h1000, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL past_ram_rd: got %h want 0", v); end
        @(negedge clk);
    endtask

    task automatic test_gpio();
        logic [31:0] v;
        addr = MMIO; write_data = 32'h0000_01A5; memwrite = 1'b1;
        #1;
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("[TB] FAIL gpio_before_edge: got %h want 00", gpio_out); end
        @(negedge clk);
        memwrite = 1'b0;
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("[TB] FAIL gpio_out: got %h want a5", gpio_out); end
        readWord(MMIO, v);
        checks++; if (v !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL gpio_rd: got %h want 000000a5", v); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("[TB] FAIL gpio_async_rst: got %h want 00", gpio_out); end
        readWord(32'h10, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_persist: got %h want deadbeef", v); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        writeWord(MMIO, 32'h0000_003C);
        readWord(MMIO + 32'h10, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_rd: got %h want 0", v); end
        @(negedge clk);
        writeWord(MMIO + 32'h10, 32'hFFFF_FFFF);
        checks++; if (gpio_out !== 8'h3C) begin errors++; $display("[TB] FAIL unmapped_gpio: got %h want 3c", gpio_out); end
        readWord(32'h10, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL unmapped_ram: got %h want deadbeef", v); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL unmapped_irq: got %b want 0", timer_irq); end
`ifdef DMEM_TIMER_EN
        readWord(MMIO + 32'h8, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL unmapped_cmp: got %h want ffffffff", v); end
`endif
        @(negedge clk);
    endtask

`ifdef DMEM_TIMER_EN
    task automatic test_timer_match();
        logic [31:0] v;
        resetDut();
        writeWord(MMIO + 32'h8, 32'd20);
        writeWord(MMIO + 32'h4, 32'd10);
        readWord(MMIO + 32'h4, v);
        checks++; if (v !== 32'd10) begin errors++; $display("[TB] FAIL mtime_load: got %h want 0000000a", v); end
        repeat (10) @(negedge clk);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_early: got %b want 0", timer_irq); end
        @(negedge clk);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_rise: got %b want 1", timer_irq); end
        readWord(MMIO + 32'hC, v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL status_rd: got %h want 1", v); end
        @(negedge clk);
        writeWord(MMIO + 32'hC, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b want 0", timer_irq); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic [31:0] expect_q [4];
        expect_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        writeWord(MMIO + 32'h4, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            readWord(MMIO + 32'h4, v);
            checks++; if (v !== expect_q[i]) begin errors++; $display("[TB] FAIL wrap_%0d: got %h want %h", i, v, expect_q[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        writeWord(MMIO + 32'h8, 32'd100);
        writeWord(MMIO + 32'h4, 32'd100);
        writeWord(MMIO + 32'hC, 32'h1);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL set_beats_clear: got %b want 1", timer_irq); end
        writeWord(MMIO + 32'hC, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL clear_after: got %b want 0", timer_irq); end
        writeWord(MMIO + 32'h4, 32'd100);
        writeWord(MMIO + 32'h8, 32'd500);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL cmp_old_match: got %b want 1", timer_irq); end
        readWord(MMIO + 32'h8, v);
        checks++; if (v !== 32'd500) begin errors++; $display("[TB] FAIL cmp_new: got %h want 000001f4", v); end
        @(negedge clk);
        writeWord(MMIO + 32'hC, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL cmp_clear: got %b want 0", timer_irq); end
    endtask
`else
    task automatic test_no_timer();
        logic [31:0] v;
        writeWord(MMIO + 32'h4, 32'h0000_1234);
        writeWord(MMIO + 32'h8, 32'h0000_1236);
        readWord(MMIO + 32'h8, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL notimer_cmp: got %h want 0", v); end
        readWord(MMIO + 32'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL notimer_status: got %h want 0", v); end
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            readWord(MMIO + 32'h4, v);
            checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL notimer_mtime_%0d: got %h want 0", i, v); end
            checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL notimer_irq_%0d: got %b want 0", i, timer_irq); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        memwrite   = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        #2;
        test_reset();
        test_ram();
        test_gpio();
        test_unmapped();
`ifdef DMEM_TIMER_EN
        test_timer_match();
        test_wrap();
        test_collision();
`else
        test_no_timer();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core's data port: it answers the core's `alu_result`/`write_data`/`memwrite` requests with `read_data`. The block contains a word-addressed RAM and a small memory-mapped peripheral region with a GPIO output register and a free-running machine timer with a compare interrupt. It sits beside the core in the top-level SoC wrapper, opposite the instruction memory.

## Interface
- `ADDR_WIDTH`, default 10: RAM depth is 2^ADDR_WIDTH 32-bit words (4 KiB at the default).
- `MMIO_BASE`, default 32'h0000_8000: base byte address of the peripheral region.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `memwrite`  in  1: write strobe from the core.
- `addr`  in  32: byte address; connects to the core's `alu_result`.
- `write_data`  in  32: store data from the core.
- `read_data`  out  32: load data to the core; combinational.
- `gpio_out`  out  8: GPIO output register.
- `timer_irq`  out  1: timer compare pending flag, level-sensitive.

## Operation
- Accesses are word-only. `addr[1:0]` is ignored and there are no byte enables.
- **RAM region** (`addr < 4·2^ADDR_WIDTH`):
  - Index is `addr[ADDR_WIDTH+1:2]`.
  - Read is asynchronous.
  - Write occurs at the clock edge when `memwrite` = 1.
  - RAM is not cleared by reset; contents persist through reset.
- **MMIO region** (`addr[31:4] == MMIO_BASE[31:4]`), byte offsets:
  - +0x0 GPIO: R/W. Low 8 bits are stored; reads return them zero-extended.
  - +0x4 MTIME: R/W. A write loads the counter.
  - +0x8 MTIMECMP: R/W.
  - +0xC STATUS: bit0 = pending. Writing 1 to bit0 clears it; other bits read 0 and ignore writes.
- **Unmapped addresses:** read 0; writes are dropped silently.
- **MTIME** increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
- **Pending flag:**
  - At each edge, if `mtime_q == mtimecmp_q`, pending is set to 1.
  - The flag is sticky until cleared through STATUS.
  - `timer_irq` = pending.
- **Simultaneous events:**
  - MTIME write and increment in the same cycle: the written value is loaded and the increment is skipped.
  - STATUS clear and a new match in the same cycle: set wins, and pending stays 1.
  - MTIMECMP write in a cycle where the old value matches: pending sets from the old value; the new value is used from the next cycle.
- **Reset values** (asynchronous, effective immediately, including mid-operation):
  - `gpio_out` = 0, MTIME = 0, MTIMECMP = 32'hFFFF_FFFF, pending = 0, `timer_irq` = 0.
  - `read_data` follows the address decode combinationally during reset. MMIO reads return the reset values.

## Timing
- Read latency is 0 cycles: `read_data` is valid in the same cycle as `addr`, which is what the single-cycle core requires.
- A write is visible to a read of the same location in the next cycle. A same-cycle read returns the old data.
- An MTIME read returns the registered value: after a write of V at edge n, the read returns V in cycle n and V+1 in cycle n+1.
- `timer_irq` asserts one edge after the cycle in which `mtime_q == mtimecmp_q`.
- A `gpio_out` update is visible on the edge after the write.

## Configuration
- `DMEM_TIMER_EN` defined: MTIME, MTIMECMP, STATUS and `timer_irq` are implemented as described above.
- `DMEM_TIMER_EN` undefined:
  - Offsets +0x4, +0x8 and +0xC read 0 and ignore writes.
  - `timer_irq` is tied to 0 and no timer flops are instantiated.
  - RAM and GPIO are unchanged.

## Structure
- Shared package `dmem_pkg` holds:
  - MMIO offset constants (`GPIO_OFS`, `MTIME_OFS`, `MTIMECMP_OFS`, `STATUS_OFS`).
  - Reset constants (`MTIMECMP_RST` = 32'hFFFF_FFFF).
  - The default `MMIO_BASE`.
- One sub-module, `dmem_timer`:
  - Contains the MTIME counter, the compare logic and the pending flag.
  - Has write-enable/data inputs per register and read outputs.
  - Is instantiated only under `DMEM_TIMER_EN`.
- Address decode, RAM array, GPIO register and the read mux stay in the top module.

## Test plan
- RAM: write 32'hDEAD_BEEF at 0x10, then read 0x10 next cycle → 32'hDEAD_BEEF. Read 0x13 → same word, because the low bits are ignored.
- GPIO: write 32'h0000_01A5 at MMIO_BASE+0x0 → `gpio_out` = 8'hA5 after the edge, and a read returns 32'h0000_00A5. Assert `reset` asynchronously mid-cycle → `gpio_out` = 0 immediately.
- Timer match:
  - Write MTIMECMP = 20, then write MTIME = 10.
  - `timer_irq` rises 11 edges after the MTIME write, and a STATUS read returns 1.
  - Write 1 to STATUS → `timer_irq` = 0 on the next edge.
- Wrap: write MTIME = 32'hFFFF_FFFE → reads return FFFF_FFFE, FFFF_FFFF, 0, 1 on consecutive cycles.
- Collision: hold MTIMECMP equal to MTIME so a match recurs, and write 1 to STATUS in the match cycle → pending remains 1.
- Unmapped and build variants:
  - Read MMIO_BASE+0x10 → 0, and a write there leaves all state unchanged.
  - Build without `DMEM_TIMER_EN`: MTIME reads 0 and `timer_irq` stays 0 across 100 cycles.
